// File: rtl/sdr_cmd_monitor.sv
// sdr_cmd_monitor: pad-side SDRAM command decoder and protocol checker.
// Tracks bank state, tRCD/tRP/refresh timing, and read-data expectation.
module sdr_cmd_monitor #(
  parameter int NB    = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   sdr_cke,
  input  logic                   sdr_cs_n,
  input  logic                   sdr_ras_n,
  input  logic                   sdr_cas_n,
  input  logic                   sdr_we_n,
  input  logic [$clog2(NB)-1:0]  sdr_ba,
  input  logic [12:0]            sdr_addr,
  input  logic [2:0]             cfg_sdr_cas,
  input  logic [3:0]             cfg_sdr_trcd_d,
  input  logic [3:0]             cfg_sdr_trp_d,
  input  logic [11:0]            cfg_sdr_rfsh,
  output logic                   cmd_valid,
  output logic [2:0]             cmd_code,
  output logic [NB-1:0]          bank_open,
  output logic                   err_trcd,
  output logic                   err_trp,
  output logic                   err_seq,
  output logic                   err_rfsh,
  output logic [3:0]             err_flags,
  output logic                   rd_expect,
  output logic [CNT_W-1:0]       rd_cnt,
  output logic [CNT_W-1:0]       wr_cnt,
  output logic [CNT_W-1:0]       rfsh_cnt
);

  localparam int BA_W = $clog2(NB);

  typedef enum logic [2:0] {
    C_NOP = 3'd0,
    C_ACT = 3'd1,
    C_RD  = 3'd2,
    C_WR  = 3'd3,
    C_PRE = 3'd4,
    C_REF = 3'd5,
    C_MRS = 3'd6,
    C_BST = 3'd7
  } cmd_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  cmd_e             cmd;
  state_e           state_q, state_d;
  logic [NB-1:0]    bank_q, bank_d;
  logic [3:0]       act_e_q [NB];
  logic [3:0]       act_e_d [NB];
  logic [3:0]       pre_e_q [NB];
  logic [3:0]       pre_e_d [NB];
  logic [11:0]      rt_q, rt_d;
  logic             rfsh_done_q, rfsh_done_d;
  logic [6:0]       sh_q;
  logic [7:0]       tap;

  logic             seq_err, trcd_err, trp_err, rfsh_due;
  logic             sel_open;
  logic             is_rd;
  logic             rd_expect_d;

  logic             cmd_valid_q;
  logic [2:0]       cmd_code_q;
  logic             err_trcd_q, err_trp_q;
  logic             err_seq_q, err_rfsh_q;
  logic [3:0]       err_flags_q;
  logic             rd_expect_q;
  logic [CNT_W-1:0] rd_cnt_q, wr_cnt_q, rfsh_cnt_q;

  logic             unused_addr;
  assign unused_addr = ^{sdr_addr[12:11], sdr_addr[9:0]};

  // Decode the pin pattern; deselect or clock-disable reads as NOP.
  always_comb begin
    cmd = C_NOP;
    if (sdr_cke && !sdr_cs_n) begin
      case ({sdr_ras_n, sdr_cas_n, sdr_we_n})
        3'b011:  cmd = C_ACT;
        3'b101:  cmd = C_RD;
        3'b100:  cmd = C_WR;
        3'b010:  cmd = C_PRE;
        3'b001:  cmd = C_REF;
        3'b000:  cmd = C_MRS;
        3'b110:  cmd = C_BST;
        default: cmd = C_NOP;
      endcase
    end
  end

  assign sel_open = bank_q[sdr_ba];
  assign is_rd    = (cmd == C_RD);

  // Global/bank next state and sequencing/timing checks for this command.
  always_comb begin
    state_d  = state_q;
    bank_d   = bank_q;
    seq_err  = 1'b0;
    trcd_err = 1'b0;
    trp_err  = 1'b0;
    case (cmd)
      C_ACT: begin
        if (state_q == ST_INIT || sel_open) begin
          seq_err = 1'b1;
        end else begin
          bank_d[sdr_ba] = 1'b1;
        end
        trp_err = (pre_e_q[sdr_ba] < cfg_sdr_trp_d);
      end
      C_RD, C_WR: begin
        if (state_q == ST_INIT || !sel_open) begin
          seq_err = 1'b1;
        end else begin
          trcd_err = (act_e_q[sdr_ba] < cfg_sdr_trcd_d);
        end
      end
      C_PRE: begin
        if (sdr_addr[10]) begin
          bank_d = '0;
        end else begin
          bank_d[sdr_ba] = 1'b0;
        end
      end
      C_REF: begin
        seq_err = |bank_q;
      end
      C_MRS: begin
        seq_err = |bank_q;
        state_d = ST_RUN;
      end
      default: begin
      end
    endcase
  end

  // Per-bank ACT/PRE elapsed counters: reload to 1, else count up to 15.
  always_comb begin
    for (int b = 0; b < NB; b++) begin
      act_e_d[b] = (act_e_q[b] == 4'd15) ? act_e_q[b] : act_e_q[b] + 4'd1;
      pre_e_d[b] = (pre_e_q[b] == 4'd15) ? pre_e_q[b] : pre_e_q[b] + 4'd1;
      if (cmd == C_ACT && sdr_ba == BA_W'(b)) begin
        act_e_d[b] = 4'd1;
      end
      if (cmd == C_PRE && (sdr_addr[10] || sdr_ba == BA_W'(b))) begin
        pre_e_d[b] = 4'd1;
      end
    end
  end

  // Refresh interval timer and one-shot overdue detection.
  always_comb begin
    rt_d        = (rt_q == 12'hfff) ? rt_q : rt_q + 12'd1;
    rfsh_due    = (state_q == ST_RUN) && (cfg_sdr_rfsh != 12'd0) &&
                  (rt_q >= cfg_sdr_rfsh) && !rfsh_done_q;
    rfsh_done_d = rfsh_done_q | rfsh_due;
    if (cmd == C_REF) begin
      rt_d        = 12'd0;
      rfsh_done_d = 1'b0;
    end
  end

  // Read strobe tap: index k holds a READ issued k cycles ago.
  always_comb begin
    tap         = {sh_q, is_rd};
    rd_expect_d = 1'b0;
    if (cfg_sdr_cas != 3'd0) begin
      rd_expect_d = tap[cfg_sdr_cas - 3'd1];
    end
  end

  // Global state and bank open flags.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_INIT;
      bank_q  <= '0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
    end
  end

  // Elapsed counters, refresh timer and read shift register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int b = 0; b < NB; b++) begin
        act_e_q[b] <= 4'd15;
        pre_e_q[b] <= 4'd15;
      end
      rt_q        <= '0;
      rfsh_done_q <= 1'b0;
      sh_q        <= '0;
    end else begin
      for (int b = 0; b < NB; b++) begin
        act_e_q[b] <= act_e_d[b];
        pre_e_q[b] <= pre_e_d[b];
      end
      rt_q        <= rt_d;
      rfsh_done_q <= rfsh_done_d;
      sh_q        <= {sh_q[5:0], is_rd};
    end
  end

  // Registered command report, error pulses and sticky flags.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cmd_valid_q <= 1'b0;
      cmd_code_q  <= 3'd0;
      err_trcd_q  <= 1'b0;
      err_trp_q   <= 1'b0;
      err_seq_q   <= 1'b0;
      err_rfsh_q  <= 1'b0;
      err_flags_q <= 4'd0;
      rd_expect_q <= 1'b0;
    end else begin
      cmd_valid_q <= (cmd != C_NOP);
      cmd_code_q  <= cmd;
      err_trcd_q  <= trcd_err;
      err_trp_q   <= trp_err;
      err_seq_q   <= seq_err;
      err_rfsh_q  <= rfsh_due;
      err_flags_q <= err_flags_q |
                     {rfsh_due, seq_err, trp_err, trcd_err};
      rd_expect_q <= rd_expect_d;
    end
  end

  // Wrapping activity counters.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      rfsh_cnt_q <= '0;
    end else begin
      if (cmd == C_RD) begin
        rd_cnt_q <= rd_cnt_q + 1'b1;
      end
      if (cmd == C_WR) begin
        wr_cnt_q <= wr_cnt_q + 1'b1;
      end
      if (cmd == C_REF) begin
        rfsh_cnt_q <= rfsh_cnt_q + 1'b1;
      end
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_code  = cmd_code_q;
  assign bank_open = bank_q;
  assign err_trcd  = err_trcd_q;
  assign err_trp   = err_trp_q;
  assign err_seq   = err_seq_q;
  assign err_rfsh  = err_rfsh_q;
  assign err_flags = err_flags_q;
  assign rd_expect = rd_expect_q;
  assign rd_cnt    = rd_cnt_q;
  assign wr_cnt    = wr_cnt_q;
  assign rfsh_cnt  = rfsh_cnt_q;

endmodule
